// File: rtl/interfaz_rx.sv
// Frame assembler between the UART receiver and the ALU: collects operand A, operand B
// and operator bytes, then presents them together with a one-cycle o_alu_valid pulse.
module interfaz_rx #(
    parameter int NB_DBIT = 8,
    parameter int NB_OPER = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DBIT-1:0] i_data,
    input  logic               i_rx_done,
    output logic [NB_DBIT-1:0] o_dato_a,
    output logic [NB_DBIT-1:0] o_dato_b,
    output logic [NB_OPER-1:0] o_operador,
    output logic               o_alu_valid,
    output logic               o_timeout
);
    localparam int                NB_CNT   = $clog2(TIMEOUT);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP} state_t;

    state_t             state_q;
    logic               rx_done_q;
    logic [NB_DBIT-1:0] shadow_a_q;
    logic [NB_DBIT-1:0] shadow_b_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic [NB_CNT-1:0]  cnt_d;
    logic               accept;
    logic               expire;

    // A strobe held high for several cycles is a single byte.
    assign accept = i_rx_done & ~rx_done_q;
    assign expire = (cnt_q == CNT_LAST);
    assign cnt_d  = cnt_q + CNT_ONE;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= WAIT_A;
            rx_done_q   <= 1'b0;
            shadow_a_q  <= '0;
            shadow_b_q  <= '0;
            cnt_q       <= '0;
            o_dato_a    <= '0;
            o_dato_b    <= '0;
            o_operador  <= '0;
            o_alu_valid <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            rx_done_q   <= i_rx_done;
            o_alu_valid <= 1'b0;
            o_timeout   <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    if (accept) begin
                        shadow_a_q <= i_data;
                        cnt_q      <= '0;
                        state_q    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // An accept on the expiry cycle still counts.
                    if (accept) begin
                        shadow_b_q <= i_data;
                        cnt_q      <= '0;
                        state_q    <= WAIT_OP;
                    end else if (expire) begin
                        o_timeout <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= WAIT_A;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_OP: begin
                    if (accept) begin
                        o_dato_a    <= shadow_a_q;
                        o_dato_b    <= shadow_b_q;
                        o_operador  <= i_data[NB_OPER-1:0];
                        o_alu_valid <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= WAIT_A;
                    end else if (expire) begin
                        o_timeout <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= WAIT_A;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_interfaz_rx.sv
// Bench for interfaz_rx: table of frames plus hand-built timeout/boundary/reset sequences,
// with a scoreboard queue popped whenever the DUT pulses o_alu_valid.
module tb_interfaz_rx;
    localparam int NB_DBIT = 8;
    localparam int NB_OPER = 6;
    localparam int TIMEOUT = 16;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [NB_DBIT-1:0] i_data = '0;
    logic               i_rx_done = 1'b0;
    logic [NB_DBIT-1:0] o_dato_a;
    logic [NB_DBIT-1:0] o_dato_b;
    logic [NB_OPER-1:0] o_operador;
    logic               o_alu_valid;
    logic               o_timeout;

    interfaz_rx #(.NB_DBIT(NB_DBIT), .NB_OPER(NB_OPER), .TIMEOUT(TIMEOUT)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_rx_done  (i_rx_done),
        .o_dato_a   (o_dato_a),
        .o_dato_b   (o_dato_b),
        .o_operador (o_operador),
        .o_alu_valid(o_alu_valid),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        int         hold;
        int         gap;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [5:0] exp_op;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
    } frame_t;

    frame_t sb[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    logic   rst_seen = 1'b0;
    int     valid_cnt = 0;
    int     valid_cyc = -1;
    int     to_cnt = 0;
    int     to_cyc = -1;
    logic   prev_valid = 1'b0;
    frame_t snap = '{8'h00, 8'h00, 6'h00};

    always @(posedge i_clk) begin
        cyc      <= cyc + 1;
        rst_seen <= i_rst;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops, hold-stability and single-cycle pulse checks.
    always @(negedge i_clk) begin
        if (cyc > 0) begin
            if (!rst_seen) begin
                chk("reset_outputs", {o_dato_a, o_dato_b, o_operador, o_alu_valid, o_timeout}, 0);
                snap       = '{8'h00, 8'h00, 6'h00};
                prev_valid = 1'b0;
            end else begin
                if (o_alu_valid) begin
                    frame_t e;
                    valid_cnt++;
                    valid_cyc = cyc;
                    chk("valid_not_consecutive", int'(prev_valid), 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("dato_a", o_dato_a, e.a);
                        chk("dato_b", o_dato_b, e.b);
                        chk("operador", o_operador, e.op);
                    end
                    snap = '{o_dato_a, o_dato_b, o_operador};
                end else begin
                    chk("fields_hold", {o_dato_a, o_dato_b, o_operador}, {snap.a, snap.b, snap.op});
                end
                if (o_timeout) begin
                    to_cnt++;
                    to_cyc = cyc;
                end
                prev_valid = o_alu_valid;
            end
        end
    end

    // Called at posedge+1 with i_rx_done low; raises the strobe right away.
    task automatic send_byte(input logic [7:0] d, input int hold, input int gap, output int start);
        i_data    = d;
        i_rx_done = 1'b1;
        start     = cyc;
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk); #1;
            i_data = ~d;
        end
        i_rx_done = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk); #1;
        end
    endtask

    vec_t vec[5];

    initial begin
        int k;
        int k3;
        int tcnt;
        int vcnt;

        vec[0] = '{8'h04, 8'h02, 8'h20, 1, 9, 8'h04, 8'h02, 6'b100000};
        vec[1] = '{8'h06, 8'h03, 8'hE2, 4, 1, 8'h06, 8'h03, 6'b100010};
        vec[2] = '{8'h01, 8'h01, 8'h22, 4, 1, 8'h01, 8'h01, 6'b100010};
        vec[3] = '{8'hFF, 8'h80, 8'hFF, 2, 3, 8'hFF, 8'h80, 6'b111111};
        vec[4] = '{8'h00, 8'h00, 8'hC0, 1, 1, 8'h00, 8'h00, 6'b000000};

        // Reset held 3 cycles with a toggling strobe.
        i_rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(posedge i_clk); #1;
            i_rx_done = ~i_rx_done;
            i_data    = 8'hA5;
        end
        i_rx_done = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        idle(2);
        chk("no_pulse_after_reset", valid_cnt + to_cnt, 0);

        // Table-driven frames; latency checked against the third strobe.
        for (int v = 0; v < 5; v++) begin
            send_byte(vec[v].a, vec[v].hold, vec[v].gap, k);
            send_byte(vec[v].b, vec[v].hold, vec[v].gap, k);
            sb.push_back('{vec[v].exp_a, vec[v].exp_b, vec[v].exp_op});
            send_byte(vec[v].opb, vec[v].hold, vec[v].gap, k3);
            chk("valid_latency", valid_cyc, k3 + 1);
        end
        idle(3);
        chk("frames_count", valid_cnt, 5);

        // Timeout: first byte then silence.
        tcnt = to_cnt;
        send_byte(8'h05, 1, 0, k);
        idle(20);
        chk("timeout_count", to_cnt, tcnt + 1);
        chk("timeout_cycle", to_cyc, k + 1 + TIMEOUT);
        vcnt = valid_cnt;
        send_byte(8'h07, 1, 1, k);
        send_byte(8'h08, 1, 1, k);
        sb.push_back('{8'h07, 8'h08, 6'b100100});
        send_byte(8'h24, 1, 1, k);
        idle(2);
        chk("frame_after_timeout", valid_cnt, vcnt + 1);

        // Boundary: second byte lands exactly on the expiry cycle.
        tcnt = to_cnt;
        send_byte(8'h11, 1, 1, k);
        while (cyc < k + TIMEOUT) begin
            @(posedge i_clk); #1;
        end
        send_byte(8'h12, 1, 1, k3);
        chk("boundary_accept_edge", k3 + 1, k + 1 + TIMEOUT);
        idle(TIMEOUT - 4);
        sb.push_back('{8'h11, 8'h12, 6'b100001});
        send_byte(8'h21, 1, 1, k);
        idle(2);
        chk("boundary_no_timeout", to_cnt, tcnt);
        chk("boundary_frame", valid_cnt, vcnt + 2);

        // Reset mid-frame, then idle past the timeout window before a new frame.
        tcnt = to_cnt;
        send_byte(8'h0A, 1, 1, k);
        send_byte(8'h0B, 1, 1, k);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        idle(TIMEOUT + 4);
        chk("reset_midframe_no_timeout", to_cnt, tcnt);
        send_byte(8'h01, 1, 1, k);
        send_byte(8'h02, 1, 1, k);
        sb.push_back('{8'h01, 8'h02, 6'b100000});
        send_byte(8'h20, 1, 1, k);
        idle(3);
        chk("reset_midframe_frame", valid_cnt, vcnt + 3);
        chk("scoreboard_empty", sb.size(), 0);
        chk("total_timeouts", to_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interfaz_rx.md
Name: interfaz_rx

Overview:
- Upstream neighbour of the ALU in the UART calculator path.
- Consumes bytes from the UART receiver and assembles one frame: operand A, then operand B, then operator.
- Presents the three fields to the ALU simultaneously and pulses o_alu_valid once per complete frame.
- Discards a partial frame and flags an error if the gap between bytes exceeds a timeout.

Parameters:
- NB_DBIT, 8, UART data byte width and ALU operand width.
- NB_OPER, 6, operator width; taken from the low NB_OPER bits of the third byte.
- TIMEOUT, 1000, max clock cycles allowed between accepted bytes inside a frame; must be >= 2.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_data  in  NB_DBIT  received byte from the UART receiver; valid when i_rx_done rises.
- i_rx_done  in  1  byte-ready strobe from the UART receiver; may stay high for more than one cycle.
- o_dato_a  out  NB_DBIT  operand A to the ALU; registered.
- o_dato_b  out  NB_DBIT  operand B to the ALU; registered.
- o_operador  out  NB_OPER  operator code to the ALU; registered.
- o_alu_valid  out  1  one-cycle pulse: the three fields hold a new frame.
- o_timeout  out  1  one-cycle pulse: a partial frame was discarded.

Behaviour:
- Reset (i_rst == 0 at a clock edge):
  - All outputs go to 0.
  - Internal shadow registers and the timeout counter clear.
  - The edge-detect register clears to 0, so an i_rx_done already high when reset releases counts as a rising edge.
  - FSM goes to WAIT_A.
  - Reset wins over every other event, including mid-frame. A partial frame is lost and no o_timeout is raised.
- Byte acceptance:
  - A byte is accepted at edge N only when i_rx_done == 1 at N and i_rx_done == 0 at N-1 (rising edge).
  - A strobe held high for several cycles counts as one byte.
- FSM states: WAIT_A, WAIT_B, WAIT_OP.
  - WAIT_A: on accept, shadow_a <= i_data; go to WAIT_B; counter <= 0. No timeout counting in WAIT_A.
  - WAIT_B: on accept, shadow_b <= i_data; go to WAIT_OP; counter <= 0.
  - WAIT_OP: on accept, the following all happen in the same edge:
    - o_dato_a <= shadow_a
    - o_dato_b <= shadow_b
    - o_operador <= i_data[NB_OPER-1:0] (upper bits ignored)
    - o_alu_valid <= 1
    - go to WAIT_A
- Latency: third byte accepted at edge N -> fields updated and o_alu_valid high from edge N until edge N+1.
- o_alu_valid is never high for two consecutive cycles.
- Output stability: o_dato_a, o_dato_b and o_operador change only on an o_alu_valid edge. The ALU sees stable operands while the next frame assembles.
- Timeout:
  - In WAIT_B and WAIT_OP, the counter increments every cycle with no accept.
  - When the counter == TIMEOUT-1 and no accept occurs in that cycle: o_timeout <= 1 for one cycle, FSM -> WAIT_A, counter <= 0. Shadow contents become don't-care.
  - Simultaneous accept and expiry: the accept wins; no timeout.
  - Counter width is ceil(log2(TIMEOUT)) bits. The counter never wraps because it is cleared at expiry.
- Back-to-back frames: a new byte may be accepted on the edge right after o_alu_valid. No dead cycle is required.
- No arithmetic is performed. Fields pass through unsigned bit-for-bit; the ALU applies any signedness.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles with i_rx_done toggling -> all outputs 0, no pulses.
- Single frame: release reset, then send 0x04, 0x02, 0x20 as 1-cycle strobes spaced 10 cycles apart -> one o_alu_valid pulse, 1 cycle after the third strobe; o_dato_a=0x04, o_dato_b=0x02, o_operador=6'b100000.
- Stretched strobe plus back-to-back frames:
  - Hold each i_rx_done high 4 cycles; send 0x06, 0x03, 0xE2, then immediately 0x01, 0x01, 0x22.
  - Expected: exactly two o_alu_valid pulses.
  - First: fields 0x06 / 0x03 / 6'b100010 (upper bits of 0xE2 dropped).
  - Second: 0x01 / 0x01 / 6'b100010.
  - Fields unchanged between the two pulses.
- Timeout (TIMEOUT=16): send 0x05, then idle 20 cycles ->
  - o_timeout pulses once, 16 cycles after the accept.
  - Then sending 0x07, 0x08, 0x24 yields o_alu_valid with 0x07 / 0x08 / 6'b100100.
  - Previous outputs are held until that pulse.
- Boundary (TIMEOUT=16): second byte arrives exactly on the expiry cycle -> accepted, no o_timeout; frame completes normally.
- Reset mid-frame: after 0x0A and 0x0B are accepted, assert i_rst for 1 cycle, then send 0x01, 0x02, 0x20 -> no o_timeout; o_alu_valid with 0x01 / 0x02 / 6'b100000.
